decoder_seq: RTL

Time-multiplexed decoder half of the quantized autoencoder. It takes one 32-value latent vector, in the same flattened format the encoder produces, and runs three dense layers (32→64→128→784) on a single multiply-accumulate datapath. Weights and biases come from an external synchronous weight memory. The 784 reconstructed pixels stream out one per handshake.

---
 rtl/decoder_seq.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/decoder_seq.sv
// decoder_seq: three dense layers (latent -> H1 -> H2 -> pixels) time-multiplexed on one MAC.
// Weights stream from an external synchronous memory: per node a bias then its fan-in weights, layers back to back.
module decoder_seq #(
    parameter int LAT_NUM      = 32,
    parameter int H1_NUM       = 64,
    parameter int H2_NUM       = 128,
    parameter int PIX_NUM      = 784,
    parameter int IN_WIDTH     = 17,
    parameter int IN_FRACTION  = 14,
    parameter int W_WIDTH      = 9,
    parameter int W_FRACTION   = 7,
    parameter int H_WIDTH      = 9,
    parameter int H_FRACTION   = 7,
    parameter int OUT_WIDTH    = 17,
    parameter int OUT_FRACTION = 14,
    parameter int ACC_WIDTH    = 32,
    parameter int WADDR_WIDTH  = 17
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [IN_WIDTH*LAT_NUM-1:0] z,
    output logic                        w_rd,
    output logic [WADDR_WIDTH-1:0]      w_addr,
    input  logic signed [W_WIDTH-1:0]   w_rdata,
    output logic                        pix_valid,
    input  logic                        pix_ready,
    output logic signed [OUT_WIDTH-1:0] pix_data,
    output logic [9:0]                  pix_idx,
    output logic                        pix_last,
    output logic                        busy
);
    localparam int CW     = $clog2(H2_NUM + 1);
    localparam int LAT_AW = $clog2(LAT_NUM);
    localparam int H1_AW  = $clog2(H1_NUM);
    localparam int H2_AW  = $clog2(H2_NUM);
    localparam int SH1    = IN_FRACTION + W_FRACTION - H_FRACTION;
    localparam int SH2    = H_FRACTION + W_FRACTION - H_FRACTION;
    localparam int SH3    = H_FRACTION + W_FRACTION - OUT_FRACTION;
    localparam logic signed [ACC_WIDTH-1:0] H_MAX = ACC_WIDTH'((1 << (H_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] O_MAX = ACC_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] O_MIN = -O_MAX - 1;

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, ACT, OUT} state_t;

    state_t                      state, state_nx;
    logic [1:0]                  layer;
    logic [9:0]                  node, node_end;
    logic [CW-1:0]               k, kd, fan_in;
    logic                        rd_d, accept, node_last, fetch_done;
    logic [WADDR_WIDTH-1:0]      addr;
    logic [H2_AW-1:0]            idx;
    logic [4:0]                  act_sh, bias_sh;
    logic signed [ACC_WIDTH-1:0] acc, prod, bias, shifted;
    logic signed [IN_WIDTH-1:0]  x;
    logic signed [H_WIDTH-1:0]   hid;
    logic signed [OUT_WIDTH-1:0] pix;
    logic signed [IN_WIDTH-1:0]  z_reg [LAT_NUM];
    logic signed [H_WIDTH-1:0]   h1 [H1_NUM];
    logic signed [H_WIDTH-1:0]   h2 [H2_NUM];

    assign accept     = state == IDLE && in_valid;
    assign in_ready   = state == IDLE;
    assign busy       = state != IDLE;
    assign w_rd       = state == FETCH;
    assign pix_valid  = state == OUT;
    assign w_addr     = addr;
    assign fan_in     = layer == 2'd0 ? CW'(LAT_NUM) : layer == 2'd1 ? CW'(H1_NUM) : CW'(H2_NUM);
    assign node_end   = layer == 2'd0 ? 10'(H1_NUM - 1) : layer == 2'd1 ? 10'(H2_NUM - 1) : 10'(PIX_NUM - 1);
    assign node_last  = node == node_end;
    assign fetch_done = k == fan_in;

    // Word kd arrived this cycle; word 0 is the bias, word j>0 pairs with input j-1.
    assign idx     = H2_AW'(kd - CW'(1));
    assign x       = layer == 2'd0 ? z_reg[idx[LAT_AW-1:0]] :
                     layer == 2'd1 ? IN_WIDTH'(h1[idx[H1_AW-1:0]]) : IN_WIDTH'(h2[idx]);
    assign prod    = ACC_WIDTH'(w_rdata) * ACC_WIDTH'(x);
    assign bias_sh = layer == 2'd0 ? 5'(IN_FRACTION) : 5'(H_FRACTION);
    assign bias    = ACC_WIDTH'(w_rdata) <<< bias_sh;

    assign act_sh  = layer == 2'd0 ? 5'(SH1) : layer == 2'd1 ? 5'(SH2) : 5'(SH3);
    assign shifted = acc >>> act_sh;
    assign hid     = shifted < 0 ? '0 : shifted > H_MAX ? H_WIDTH'(H_MAX) : shifted[H_WIDTH-1:0];
    assign pix     = shifted > O_MAX ? OUT_WIDTH'(O_MAX) :
                     shifted < O_MIN ? OUT_WIDTH'(O_MIN) : shifted[OUT_WIDTH-1:0];

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = FETCH;
            FETCH:   if (fetch_done) state_nx = DRAIN;
            DRAIN:   state_nx = ACT;
            ACT:     state_nx = layer == 2'd2 ? OUT : FETCH;
            OUT:     if (pix_ready) state_nx = pix_last ? IDLE : FETCH;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer    <= '0;
            node     <= '0;
            k        <= '0;
            kd       <= '0;
            rd_d     <= 1'b0;
            addr     <= '0;
            acc      <= '0;
            pix_data <= '0;
            pix_idx  <= '0;
            pix_last <= 1'b0;
        end else begin
            rd_d <= w_rd;
            kd   <= k;
            if (accept) begin
                layer <= '0;
                node  <= '0;
                k     <= '0;
                addr  <= '0;
            end
            // Layers are contiguous in memory, so the address simply runs for the whole vector.
            if (w_rd) begin
                addr <= addr + 1'b1;
                k    <= fetch_done ? '0 : k + 1'b1;
            end
            if (rd_d) acc <= kd == '0 ? bias : acc + prod;
            if (state == ACT && layer == 2'd2) begin
                pix_data <= pix;
                pix_idx  <= node;
                pix_last <= node_last;
            end
            if (state == ACT && layer != 2'd2) begin
                node <= node_last ? '0 : node + 1'b1;
                if (node_last) layer <= layer + 1'b1;
            end
            if (pix_valid && pix_ready) node <= node + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LAT_NUM; i++)
            if (accept) z_reg[i] <= signed'(z[i*IN_WIDTH +: IN_WIDTH]);
        if (state == ACT && layer == 2'd0) h1[node[H1_AW-1:0]] <= hid;
        if (state == ACT && layer == 2'd1) h2[node[H2_AW-1:0]] <= hid;
    end
endmodule
